// File: rtl/seq_match_pkg.sv
// seq_match_pkg: shared types and defaults for the serial pattern match controller.
// Optional feature macro used by this slice: SEQ_MATCH_TIMEOUT_EN.
package seq_match_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width needed to hold a pattern length from 0 up to maxLen inclusive.
    function automatic int lenWidth(input int maxLen);
        return $clog2(maxLen + 1);
    endfunction

endpackage

// File: rtl/seq_match_ctrl_if.sv
// seq_match_ctrl_if: configuration, control and serial stream signals of the match controller.
// With SEQ_MATCH_TIMEOUT_EN defined the interface also carries the timeout flag.
interface seq_match_ctrl_if
    import seq_match_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W
);
    localparam int LEN_W = lenWidth(MAX_LEN);

    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic [CNT_W-1:0]   cfg_thresh;
    logic               cfg_overlap;
    logic               cfg_err;
    logic               arm;
    logic               abort;
    logic               In;
    logic               in_valid;
    logic               Out;
    logic [CNT_W-1:0]   match_cnt;
    logic               busy;
    logic               done;
`ifdef SEQ_MATCH_TIMEOUT_EN
    logic               timeout;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_thresh, cfg_overlap, arm, abort, In, in_valid,
        input  cfg_ready, cfg_err, Out, match_cnt, busy, done, timeout
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_thresh, cfg_overlap, arm, abort, In, in_valid,
        output cfg_ready, cfg_err, Out, match_cnt, busy, done, timeout
    );
`else
    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_thresh, cfg_overlap, arm, abort, In, in_valid,
        input  cfg_ready, cfg_err, Out, match_cnt, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_thresh, cfg_overlap, arm, abort, In, in_valid,
        output cfg_ready, cfg_err, Out, match_cnt, busy, done
    );
`endif

endinterface

// File: rtl/seq_match_window.sv
// seq_window: serial shift window with fill tracking and a length-masked pattern compare.
// hit is combinational and looks at the window as it will be after the current shift.
module seq_window
    import seq_match_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = lenWidth(DEF_MAX_LEN)
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               shift,
    input  logic               din,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    output logic               hit
);
    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] winNext;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fillInc;
    logic               patEq;

    assign winNext = {window[MAX_LEN-2:0], din};
    assign fillInc = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;

    // Compare only the newest len bits of the shifted window against the pattern.
    always_comb begin
        patEq = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) < len) && (winNext[i] != pattern[i])) begin
                patEq = 1'b0;
            end
        end
    end

    assign hit = shift && (fillInc >= len) && patEq;

    // Shift in new bits; a non-overlapping match restarts the fill so the next match needs fresh bits.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            window <= '0;
            fill   <= '0;
        end else if (shift) begin
            window <= winNext;
            fill   <= (hit && !overlap) ? '0 : fillInc;
        end
    end

endmodule

// File: rtl/seq_match_ctrl.sv
// seq_match_ctrl: configures, arms and sequences a programmable bit-serial pattern detector.
// Define SEQ_MATCH_TIMEOUT_EN to add an inactivity timeout that forces DONE and raises timeout.
module seq_match_ctrl
    import seq_match_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W
)
(
    input logic             clk,
    input logic             rst,
    seq_match_ctrl_if.slave bus
);
    localparam int LEN_W = lenWidth(MAX_LEN);

    state_t             state;
    state_t             stateNext;
    logic [MAX_LEN-1:0] patternReg;
    logic [LEN_W-1:0]   lenReg;
    logic [CNT_W-1:0]   threshReg;
    logic [CNT_W-1:0]   matchCnt;
    logic [CNT_W-1:0]   cntInc;
    logic               overlapReg;
    logic               cfgLoaded;
    logic               cfgErr;
    logic               outReg;
    logic               cfgReady;
    logic               cfgXfer;
    logic               lenLegal;
    logic               armAccept;
    logic               shiftEn;
    logic               hit;
    logic               threshHit;
    logic               toHit;
    logic               busy;
    logic               done;

    assign cfgReady  = (state == IDLE) || (state == DONE);
    assign cfgXfer   = bus.cfg_valid && cfgReady;
    assign lenLegal  = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
    assign armAccept = bus.arm && !bus.abort && ((state != IDLE) || cfgLoaded);
    assign shiftEn   = (state == ARMED) && bus.in_valid && !bus.abort && !bus.arm;
    assign cntInc    = (matchCnt == '1) ? matchCnt : matchCnt + 1'b1;
    assign threshHit = hit && (threshReg != '0) && (cntInc == threshReg);

    seq_window #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) uWindow (
        .clk     (clk),
        .rst     (rst),
        .clr     (armAccept),
        .shift   (shiftEn),
        .din     (bus.In),
        .pattern (patternReg),
        .len     (lenReg),
        .overlap (overlapReg),
        .hit     (hit)
    );

`ifdef SEQ_MATCH_TIMEOUT_EN
    logic [CNT_W-1:0] idleCnt;
    logic             timeoutReg;

    assign toHit = shiftEn && !hit && (idleCnt == ~CNT_W'(1));

    // Count accepted bits since the last match or arm and latch timeout when the count tops out.
    always_ff @(posedge clk) begin
        if (rst) begin
            idleCnt    <= '0;
            timeoutReg <= 1'b0;
        end else if (bus.abort || armAccept) begin
            idleCnt    <= '0;
            timeoutReg <= 1'b0;
        end else if (shiftEn) begin
            idleCnt <= hit ? '0 : idleCnt + 1'b1;
            if (toHit) begin
                timeoutReg <= 1'b1;
            end
        end
    end

    assign bus.timeout = timeoutReg;
`else
    assign toHit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state selection and state-decoded status flags; abort outranks arm, which outranks a match.
    always_comb begin
        stateNext = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (armAccept) begin
                    stateNext = ARMED;
                end
            end
            ARMED: begin
                busy = 1'b1;
                if (bus.abort) begin
                    stateNext = IDLE;
                end else if (bus.arm) begin
                    stateNext = ARMED;
                end else if (threshHit || toHit) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (bus.abort) begin
                    stateNext = IDLE;
                end else if (bus.arm) begin
                    stateNext = ARMED;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Configuration capture, error pulse, match pulse and the saturating match counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            patternReg <= '0;
            lenReg     <= LEN_W'(1);
            threshReg  <= '0;
            overlapReg <= 1'b0;
            cfgLoaded  <= 1'b0;
            cfgErr     <= 1'b0;
            outReg     <= 1'b0;
            matchCnt   <= '0;
        end else begin
            cfgErr <= cfgXfer && !lenLegal;
            outReg <= hit;
            if (cfgXfer && lenLegal) begin
                patternReg <= bus.cfg_pattern;
                lenReg     <= bus.cfg_len;
                threshReg  <= bus.cfg_thresh;
                overlapReg <= bus.cfg_overlap;
                cfgLoaded  <= 1'b1;
            end
            if (armAccept) begin
                matchCnt <= '0;
            end else if (hit) begin
                matchCnt <= cntInc;
            end
        end
    end

    assign bus.cfg_ready = cfgReady;
    assign bus.cfg_err   = cfgErr;
    assign bus.Out       = outReg;
    assign bus.match_cnt = matchCnt;
    assign bus.busy      = busy;
    assign bus.done      = done;

endmodule
